data_serial_tx: RTL and testbench

//  Transmit-side counterpart of the recovered-data capture path. Accepts DATA_WIDTH-bit

---
 rtl/data_serial_tx.sv | 152 +++++++++++++++
 tb/tb_data_serial_tx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_serial_tx.sv
// data_serial_tx - framed serial transmitter: sync pattern, MSB-first data, optional even parity, idle gap.
// Single holding register in front of a shift register so the next word can queue during a frame.
module data_serial_tx #(
  parameter int                     DATA_WIDTH   = 14,
  parameter int                     DIV          = 4,
  parameter int                     SYNC_LEN     = 4,
  parameter logic [SYNC_LEN-1:0]    SYNC_PATTERN = 4'b1010,
  parameter int                     PARITY_EN    = 1,
  parameter int                     GAP_BITS     = 1
) (
  input  logic                  clock_50,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_stand,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  tx_data,
  output logic                  tx_strobe,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int TW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int MAX1 = (DATA_WIDTH > SYNC_LEN) ? DATA_WIDTH : SYNC_LEN;
  localparam int MAXB = (MAX1 > GAP_BITS) ? MAX1 : GAP_BITS;
  localparam int CW   = $clog2(MAXB + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_PARITY,
    S_GAP
  } state_t;

  state_t                r_state;
  logic [TW-1:0]         r_timer;
  logic [CW-1:0]         r_bitcnt;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_full;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [SYNC_LEN-1:0]   r_sync;
  logic                  r_parity;

  logic w_accept;
  logic w_tick;
  logic w_gap_end;
  logic w_start;

  assign data_ready = ~r_hold_full & ~reset;
  assign w_accept   = data_valid & data_ready;
  assign w_tick     = (r_state != S_IDLE) && (r_timer == '0);
  assign w_gap_end  = (r_state == S_GAP) && w_tick && (r_bitcnt == CW'(GAP_BITS - 1));
  // A queued word starts either from IDLE or directly on the last gap edge.
  assign w_start    = r_hold_full && ((r_state == S_IDLE) || w_gap_end);

  always_ff @(posedge clock_50) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_bitcnt    <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_sync      <= '0;
      r_parity    <= 1'b0;
      tx_data     <= 1'b0;
      tx_strobe   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= w_gap_end;
      tx_strobe  <= 1'b0;

      if (w_accept) begin
        r_hold      <= data_stand;
        r_hold_full <= 1'b1;
      end else if (w_start) begin
        r_hold_full <= 1'b0;
      end

      if (r_state != S_IDLE && r_timer != '0) begin
        r_timer <= r_timer - 1'b1;
      end

      if (w_start) begin
        r_shift   <= r_hold;
        r_sync    <= SYNC_PATTERN << 1;
        r_parity  <= 1'b0;
        r_bitcnt  <= '0;
        r_state   <= S_SYNC;
        r_timer   <= TW'(DIV - 1);
        tx_data   <= SYNC_PATTERN[SYNC_LEN-1];
        tx_strobe <= 1'b1;
        busy      <= 1'b1;
      end else if (w_tick) begin
        r_timer   <= TW'(DIV - 1);
        tx_strobe <= 1'b1;
        r_bitcnt  <= r_bitcnt + 1'b1;
        case (r_state)
          S_SYNC: begin
            if (r_bitcnt == CW'(SYNC_LEN - 1)) begin
              r_state  <= S_DATA;
              r_bitcnt <= '0;
              tx_data  <= r_shift[DATA_WIDTH-1];
              r_parity <= r_parity ^ r_shift[DATA_WIDTH-1];
              r_shift  <= r_shift << 1;
            end else begin
              tx_data <= r_sync[SYNC_LEN-1];
              r_sync  <= r_sync << 1;
            end
          end
          S_DATA: begin
            if (r_bitcnt == CW'(DATA_WIDTH - 1)) begin
              r_bitcnt <= '0;
              if (PARITY_EN != 0) begin
                r_state <= S_PARITY;
                tx_data <= r_parity;
              end else begin
                r_state <= S_GAP;
                tx_data <= 1'b0;
              end
            end else begin
              tx_data  <= r_shift[DATA_WIDTH-1];
              r_parity <= r_parity ^ r_shift[DATA_WIDTH-1];
              r_shift  <= r_shift << 1;
            end
          end
          S_PARITY: begin
            r_state  <= S_GAP;
            r_bitcnt <= '0;
            tx_data  <= 1'b0;
          end
          S_GAP: begin
            tx_data <= 1'b0;
            if (r_bitcnt == CW'(GAP_BITS - 1)) begin
              r_state   <= S_IDLE;
              r_bitcnt  <= '0;
              tx_strobe <= 1'b0;
              busy      <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            tx_data <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_serial_tx.sv
// tb/tb_data_serial_tx.sv - frame-level reference model and directed/random checks for data_serial_tx.
module tb_data_serial_tx;

  localparam int DIV  = 4;
  localparam int FLEN = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] d_stand;
  logic        d_valid;
  logic        d_ready, tx, stb, bsy, done;

  logic [13:0] d2_stand;
  logic        d2_valid;
  logic        d2_ready, tx2, stb2, bsy2, done2;

  always #5 clk = ~clk;

  data_serial_tx u_dut (
    .clock_50(clk), .reset(rst), .data_stand(d_stand), .data_valid(d_valid),
    .data_ready(d_ready), .tx_data(tx), .tx_strobe(stb), .busy(bsy), .frame_done(done)
  );

  data_serial_tx #(.DIV(2), .PARITY_EN(0)) u_dut2 (
    .clock_50(clk), .reset(rst), .data_stand(d2_stand), .data_valid(d2_valid),
    .data_ready(d2_ready), .tx_data(tx2), .tx_strobe(stb2), .busy(bsy2), .frame_done(done2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: whole frame as a bit list, output indexed by cycle-in-frame.
  function automatic logic [FLEN-1:0] frame_bits(input logic [13:0] w);
    return {4'b1010, w, ^w, 1'b0};
  endfunction

  bit          m_active = 0;
  bit          m_hold_full = 0;
  bit          m_done = 0;
  logic [13:0] m_hold = '0;
  logic [FLEN-1:0] m_fb = '0;
  int          m_k = 0;
  int          ecyc = 0;
  int          start_edges[$];

  always @(posedge clk) begin
    bit acc;
    ecyc++;
    if (rst) begin
      m_active = 0; m_hold_full = 0; m_done = 0;
    end else begin
      acc = d_valid && !m_hold_full;
      m_done = 0;
      if (m_active) begin
        m_k++;
        if (m_k == FLEN * DIV) begin
          m_done = 1; m_active = 0;
        end
      end
      if (!m_active && m_hold_full) begin
        m_fb = frame_bits(m_hold); m_k = 0; m_active = 1; m_hold_full = 0;
        start_edges.push_back(ecyc);
      end
      if (acc) begin
        m_hold_full = 1; m_hold = d_stand;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("tx_data", tx, m_active ? m_fb[FLEN-1 - m_k / DIV] : 1'b0);
      chk("tx_strobe", stb, m_active && (m_k % DIV == 0));
      chk("busy", bsy, m_active);
      chk("frame_done", done, m_done);
      chk("data_ready", d_ready, !m_hold_full && !rst);
    end
  end

  int   cyc = 0;
  int   first_strobe = -1;
  int   done_cyc = -1;
  int   done_cnt = 0;
  logic cap[$];
  int   strobe_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (stb === 1'b1) begin
      cap.push_back(tx);
      strobe_cyc.push_back(cyc);
      if (first_strobe < 0) first_strobe = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap.delete(); strobe_cyc.delete();
    first_strobe = -1; done_cyc = -1; done_cnt = 0;
  endtask

  task automatic send(input logic [13:0] w, output int acc_edge);
    bit pend;
    acc_edge = -1;
    d_stand = w; d_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      pend = !m_hold_full && !rst;
      step();
      if (pend) begin
        acc_edge = ecyc;
        break;
      end
    end
    if (acc_edge < 0) chk_int("send_timeout", 0, 1);
    d_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 500) begin
      step();
      n++;
    end
    if (done_cnt < target) chk_int("frame_done_timeout", done_cnt, target);
  endtask

  initial begin
    int e, e3;
    logic [19:0] v20;
    logic [18:0] v19;
    int f1, fd2, nb;
    logic b2[$];
    int s2[$];
    bit spacing_ok;

    rst = 1'b1; d_valid = 1'b0; d_stand = '0; d2_valid = 1'b0; d2_stand = '0;
    step();
    check_en = 1;
    step();
    chk("reset_busy", bsy, 1'b0);
    chk("reset_ready", d_ready, 1'b0);
    rst = 1'b0;
    step();

    // Frame 0x2A5C: bits at strobes and frame_done spacing.
    clear_cap();
    send(14'h2A5C, e);
    wait_done(1);
    step();
    chk_int("t2_bitcount", cap.size(), 20);
    v20 = '0;
    for (int i = 0; i < 20 && i < cap.size(); i++) v20[19-i] = cap[i];
    chk_int("t2_bits", int'(v20), int'(20'b1010_10101001011100_1_0));
    chk_int("t2_done_latency", done_cyc - first_strobe, 80);

    // Reset in the middle of the data field.
    clear_cap();
    send(14'h1234, e);
    repeat (30) step();
    rst = 1'b1;
    step();
    chk("t1_tx", tx, 1'b0);
    chk("t1_busy", bsy, 1'b0);
    chk("t1_strobe", stb, 1'b0);
    chk("t1_ready", d_ready, 1'b0);
    rst = 1'b0;
    step();
    chk("t1_ready_after", d_ready, 1'b1);
    repeat (100) step();
    chk_int("t1_no_done", done_cnt, 0);

    // Back-to-back 0x0000 / 0x3FFF, then a third word queued behind them.
    clear_cap();
    start_edges.delete();
    send(14'h0000, e);
    send(14'h3FFF, e);
    send(14'h2C71, e3);
    wait_done(3);
    step();
    chk_int("t3_bitcount", cap.size(), 60);
    if (cap.size() >= 60) begin
      chk("t3_parity1", cap[18], 1'b0);
      chk("t3_parity2", cap[38], 1'b0);
      chk_int("t3_f2_gap", strobe_cyc[20] - strobe_cyc[19], DIV);
      v20 = '0;
      for (int i = 0; i < 20; i++) v20[19-i] = cap[40+i];
      chk_int("t4_frame3", int'(v20), int'(frame_bits(14'h2C71)));
    end
    if (start_edges.size() >= 2) chk_int("t4_accept_edge", e3, start_edges[1] + 1);
    else chk_int("t4_starts", start_edges.size(), 3);

    // Random valid/data churn with occasional resets; the model checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      d_valid = 1'($urandom_range(0, 1));
      d_stand = 14'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; d_valid = 1'b0;
    repeat (200) step();

    // No-parity, DIV=2 instance.
    d2_stand = 14'h1555; d2_valid = 1'b1;
    step();
    d2_valid = 1'b0; d2_stand = 14'h3FFF;
    f1 = -1; fd2 = -1; nb = 0;
    for (int i = 0; i < 100 && fd2 < 0; i++) begin
      @(negedge clk);
      nb++;
      if (stb2 === 1'b1) begin
        b2.push_back(tx2); s2.push_back(nb);
        if (f1 < 0) f1 = nb;
      end
      if (done2 === 1'b1) fd2 = nb;
    end
    chk_int("t5_bitcount", b2.size(), 19);
    v19 = '0;
    for (int i = 0; i < 19 && i < b2.size(); i++) v19[18-i] = b2[i];
    chk_int("t5_bits", int'(v19), int'(19'b1010_01010101010101_0));
    chk_int("t5_done_latency", fd2 - f1, 38);
    spacing_ok = 1;
    for (int i = 1; i < s2.size(); i++) if (s2[i] - s2[i-1] != 2) spacing_ok = 0;
    chk("t5_strobe_spacing", spacing_ok, 1'b1);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
